// File: rtl/rvfi_retire_compare_pkg.sv
// ---------------------------------------------------------------------------
// rvfi_retire_compare_pkg : shared types for the RVFI retirement comparator.
// Revision: 1.0
// Optional mem compare is enabled by RVFI_RETIRE_COMPARE_MEM_EN.
// ---------------------------------------------------------------------------
`default_nettype none

package rvfi_retire_compare_pkg;

  // Entries are sized for the widest supported XLEN; narrower inputs are zero-extended.
  localparam int MAX_XLEN = 64;

  typedef enum logic [3:0] {
    FC_NONE     = 4'd0,
    FC_ORDER    = 4'd1,
    FC_PC       = 4'd2,
    FC_INSN     = 4'd3,
    FC_TRAP     = 4'd4,
    FC_RD       = 4'd5,
    FC_MEM      = 4'd6,
    FC_OVERFLOW = 4'd7,
    FC_TIMEOUT  = 4'd8
  } fail_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  typedef struct packed {
    logic [63:0]         order;
    logic [MAX_XLEN-1:0] pc;
    logic [31:0]         insn;
    logic [4:0]          rd_addr;
    logic [MAX_XLEN-1:0] rd_wdata;
    logic                trap;
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    logic [MAX_XLEN-1:0]   mem_addr;
    logic [MAX_XLEN-1:0]   mem_wdata;
    logic [MAX_XLEN/8-1:0] mem_wmask;
`endif
  } entry_t;

  // First differing field in priority order; FC_NONE when the pair matches.
  function automatic fail_code_e compare_entries(input entry_t d, input entry_t r);
    fail_code_e code;
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    logic mem_diff;
    mem_diff = (d.mem_addr != r.mem_addr) || (d.mem_wmask != r.mem_wmask);
    for (int b = 0; b < MAX_XLEN / 8; b++) begin
      if (d.mem_wmask[b] && (d.mem_wdata[8*b +: 8] != r.mem_wdata[8*b +: 8])) begin
        mem_diff = 1'b1;
      end
    end
`endif
    code = FC_NONE;
    if (d.order != r.order) begin
      code = FC_ORDER;
    end else if (d.pc != r.pc) begin
      code = FC_PC;
    end else if (d.insn != r.insn) begin
      code = FC_INSN;
    end else if (d.trap != r.trap) begin
      code = FC_TRAP;
    end else if ((d.rd_addr != r.rd_addr) ||
                 ((d.rd_addr != 5'd0) && (d.rd_wdata != r.rd_wdata))) begin
      code = FC_RD;
    end
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    else if (mem_diff) begin
      code = FC_MEM;
    end
`endif
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvfi_retire_compare_if.sv
// ---------------------------------------------------------------------------
// rvfi_retire_compare_if : DUT/reference retirement streams and checker results.
// Revision: 1.0   (mem fields present with RVFI_RETIRE_COMPARE_MEM_EN)
// ---------------------------------------------------------------------------
`default_nettype none

interface rvfi_retire_compare_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import rvfi_retire_compare_pkg::*;

  logic            dut_valid;
  logic [63:0]     dut_order;
  logic [XLEN-1:0] dut_pc;
  logic [31:0]     dut_insn;
  logic [4:0]      dut_rd_addr;
  logic [XLEN-1:0] dut_rd_wdata;
  logic            dut_trap;

  logic            ref_valid;
  logic [63:0]     ref_order;
  logic [XLEN-1:0] ref_pc;
  logic [31:0]     ref_insn;
  logic [4:0]      ref_rd_addr;
  logic [XLEN-1:0] ref_rd_wdata;
  logic            ref_trap;

`ifdef RVFI_RETIRE_COMPARE_MEM_EN
  logic [XLEN-1:0]   dut_mem_addr;
  logic [XLEN-1:0]   dut_mem_wdata;
  logic [XLEN/8-1:0] dut_mem_wmask;
  logic [XLEN-1:0]   ref_mem_addr;
  logic [XLEN-1:0]   ref_mem_wdata;
  logic [XLEN/8-1:0] ref_mem_wmask;
`endif

  logic             cmp_valid;
  logic             cmp_pass;
  logic             fail;
  fail_code_e       fail_code;
  logic [63:0]      fail_order;
  logic [CNT_W-1:0] checked_cnt;

  modport master (
    output dut_valid, dut_order, dut_pc, dut_insn, dut_rd_addr, dut_rd_wdata, dut_trap,
    output ref_valid, ref_order, ref_pc, ref_insn, ref_rd_addr, ref_rd_wdata, ref_trap,
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    output dut_mem_addr, dut_mem_wdata, dut_mem_wmask,
    output ref_mem_addr, ref_mem_wdata, ref_mem_wmask,
`endif
    input  cmp_valid, cmp_pass, fail, fail_code, fail_order, checked_cnt
  );

  modport slave (
    input  dut_valid, dut_order, dut_pc, dut_insn, dut_rd_addr, dut_rd_wdata, dut_trap,
    input  ref_valid, ref_order, ref_pc, ref_insn, ref_rd_addr, ref_rd_wdata, ref_trap,
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    input  dut_mem_addr, dut_mem_wdata, dut_mem_wmask,
    input  ref_mem_addr, ref_mem_wdata, ref_mem_wmask,
`endif
    output cmp_valid, cmp_pass, fail, fail_code, fail_order, checked_cnt
  );

endinterface

`default_nettype wire

// File: rtl/rvfi_retire_fifo.sv
// ---------------------------------------------------------------------------
// rvfi_retire_fifo : show-ahead FIFO of retirement entries; push on full is
// accepted when a pop happens in the same cycle.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rvfi_retire_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/rvfi_retire_compare.sv
// ---------------------------------------------------------------------------
// rvfi_retire_compare : pairs DUT and reference retirements in order and
// latches the first divergence, overflow or stall.   Revision: 1.0
// Optional mem compare: define RVFI_RETIRE_COMPARE_MEM_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module rvfi_retire_compare
  import rvfi_retire_compare_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rvfi_retire_compare_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e     state;
  logic [TMO_W-1:0] tmo_cnt;
  entry_t     dut_entry, ref_entry, dut_head, ref_head;
  logic       dut_full, dut_empty, ref_full, ref_empty;
  logic       dut_push, ref_push, pop, running;
  logic       mismatch, overflow, one_sided, timeout;
  fail_code_e cmp_code;

  always_comb begin
    dut_entry          = '0;
    dut_entry.order    = bus.dut_order;
    dut_entry.pc       = MAX_XLEN'(bus.dut_pc);
    dut_entry.insn     = bus.dut_insn;
    dut_entry.rd_addr  = bus.dut_rd_addr;
    dut_entry.rd_wdata = MAX_XLEN'(bus.dut_rd_wdata);
    dut_entry.trap     = bus.dut_trap;
    ref_entry          = '0;
    ref_entry.order    = bus.ref_order;
    ref_entry.pc       = MAX_XLEN'(bus.ref_pc);
    ref_entry.insn     = bus.ref_insn;
    ref_entry.rd_addr  = bus.ref_rd_addr;
    ref_entry.rd_wdata = MAX_XLEN'(bus.ref_rd_wdata);
    ref_entry.trap     = bus.ref_trap;
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    dut_entry.mem_addr  = MAX_XLEN'(bus.dut_mem_addr);
    dut_entry.mem_wdata = MAX_XLEN'(bus.dut_mem_wdata);
    dut_entry.mem_wmask = (MAX_XLEN/8)'(bus.dut_mem_wmask);
    ref_entry.mem_addr  = MAX_XLEN'(bus.ref_mem_addr);
    ref_entry.mem_wdata = MAX_XLEN'(bus.ref_mem_wdata);
    ref_entry.mem_wmask = (MAX_XLEN/8)'(bus.ref_mem_wmask);
`endif
  end

  assign running   = (state == ST_RUN);
  assign dut_push  = bus.dut_valid && (state != ST_FAIL);
  assign ref_push  = bus.ref_valid && (state != ST_FAIL);
  assign pop       = running && !dut_empty && !ref_empty;
  assign cmp_code  = compare_entries(dut_head, ref_head);
  assign mismatch  = pop && (cmp_code != FC_NONE);
  // Both FIFOs pop together, so a push onto a full FIFO is only illegal when no pair pops.
  assign overflow  = running && !pop &&
                     ((bus.dut_valid && dut_full) || (bus.ref_valid && ref_full));
  assign one_sided = running && (dut_empty != ref_empty);
  assign timeout   = one_sided && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  rvfi_retire_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_dut_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (dut_push),
    .push_data (dut_entry),
    .pop       (pop),
    .head      (dut_head),
    .full      (dut_full),
    .empty     (dut_empty)
  );

  rvfi_retire_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_ref_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ref_push),
    .push_data (ref_entry),
    .pop       (pop),
    .head      (ref_head),
    .full      (ref_full),
    .empty     (ref_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      tmo_cnt         <= '0;
      bus.cmp_valid   <= 1'b0;
      bus.cmp_pass    <= 1'b0;
      bus.fail        <= 1'b0;
      bus.fail_code   <= FC_NONE;
      bus.fail_order  <= '0;
      bus.checked_cnt <= '0;
    end else begin
      bus.cmp_valid <= pop;
      bus.cmp_pass  <= pop && !mismatch;
      if (pop && !mismatch && (bus.checked_cnt != '1)) begin
        bus.checked_cnt <= bus.checked_cnt + CNT_W'(1);
      end
      tmo_cnt <= one_sided ? tmo_cnt + TMO_W'(1) : '0;
      case (state)
        ST_IDLE: begin
          if (dut_push || ref_push) state <= ST_RUN;
        end
        ST_RUN: begin
          if (mismatch) begin
            state          <= ST_FAIL;
            bus.fail       <= 1'b1;
            bus.fail_code  <= cmp_code;
            bus.fail_order <= dut_head.order;
          end else if (overflow) begin
            state          <= ST_FAIL;
            bus.fail       <= 1'b1;
            bus.fail_code  <= FC_OVERFLOW;
            bus.fail_order <= dut_empty ? 64'd0 : dut_head.order;
          end else if (timeout) begin
            state          <= ST_FAIL;
            bus.fail       <= 1'b1;
            bus.fail_code  <= FC_TIMEOUT;
            bus.fail_order <= 64'd0;
          end
        end
        default: state <= ST_FAIL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rvfi_retire_compare.sv
// ---------------------------------------------------------------------------
// tb_rvfi_retire_compare : directed self-checking bench for rvfi_retire_compare.
// Revision: 1.0   (mem cases compiled with RVFI_RETIRE_COMPARE_MEM_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rvfi_retire_compare;
  import rvfi_retire_compare_pkg::*;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   valid_pulses = 0;
  int   pass_pulses = 0;
  int   base_v;
  int   base_p;

  rvfi_retire_compare_if #(.XLEN(32), .CNT_W(32)) bus ();

  rvfi_retire_compare #(
    .XLEN(32), .DEPTH(8), .TIMEOUT_CYCLES(1024), .CNT_W(32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cmp_valid) begin
      valid_pulses++;
      if (bus.cmp_pass) pass_pulses++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_pc(input int i);
    return 32'h8000_0000 + 32'(i * 4);
  endfunction

  function automatic logic [31:0] gen_insn(input int i);
    return 32'h0000_0013 | (32'(i % 32) << 7);
  endfunction

  task automatic set_dut(input int i);
    bus.dut_valid    = 1'b1;
    bus.dut_order    = 64'(i);
    bus.dut_pc       = gen_pc(i);
    bus.dut_insn     = gen_insn(i);
    bus.dut_rd_addr  = 5'(i % 32);
    bus.dut_rd_wdata = 32'(i) * 32'h0101_0101;
    bus.dut_trap     = (i % 17 == 16);
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    bus.dut_mem_addr  = 32'h1000 + 32'(i * 4);
    bus.dut_mem_wdata = ~gen_pc(i);
    bus.dut_mem_wmask = 4'(i % 16);
`endif
  endtask

  task automatic set_ref(input int i);
    bus.ref_valid    = 1'b1;
    bus.ref_order    = 64'(i);
    bus.ref_pc       = gen_pc(i);
    bus.ref_insn     = gen_insn(i);
    bus.ref_rd_addr  = 5'(i % 32);
    bus.ref_rd_wdata = 32'(i) * 32'h0101_0101;
    bus.ref_trap     = (i % 17 == 16);
`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    bus.ref_mem_addr  = 32'h1000 + 32'(i * 4);
    bus.ref_mem_wdata = ~gen_pc(i);
    bus.ref_mem_wmask = 4'(i % 16);
`endif
  endtask

  task automatic clear_inputs();
    bus.dut_valid = 1'b0;
    bus.ref_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    base_v = valid_pulses;
    base_p = pass_pulses;
  endtask

  initial begin
    reset_n = 1'b0;
    set_dut(0);
    set_ref(0);
    clear_inputs();
    repeat (2) step();
    check("rst_cmp_valid",   64'(bus.cmp_valid),   64'd0);
    check("rst_fail",        64'(bus.fail),        64'd0);
    check("rst_fail_code",   64'(bus.fail_code),   64'(FC_NONE));
    check("rst_fail_order",  bus.fail_order,       64'd0);
    check("rst_checked_cnt", 64'(bus.checked_cnt), 64'd0);
    reset_n = 1'b1;
    step();
    base_v = valid_pulses;
    base_p = pass_pulses;

    // 100 identical retirements, reference lagging by 3 cycles
    for (int c = 0; c < 103; c++) begin
      clear_inputs();
      if (c < 100) set_dut(c);
      if (c >= 3) set_ref(c - 3);
      step();
    end
    clear_inputs();
    repeat (4) step();
    check("lag_valid_pulses", 64'(valid_pulses - base_v), 64'd100);
    check("lag_pass_pulses",  64'(pass_pulses - base_p),  64'd100);
    check("lag_checked_cnt",  64'(bus.checked_cnt),       64'd100);
    check("lag_fail",         64'(bus.fail),              64'd0);
    check("lag_fail_code",    64'(bus.fail_code),         64'(FC_NONE));

    // PC divergence on pair 5
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_dut(i);
      set_ref(i);
      if (i == 5) bus.dut_pc = 32'h8000_0018;
      step();
    end
    clear_inputs();
    repeat (5) step();
    check("pc_fail",         64'(bus.fail),              64'd1);
    check("pc_fail_code",    64'(bus.fail_code),         64'(FC_PC));
    check("pc_fail_order",   bus.fail_order,             64'd5);
    check("pc_checked_cnt",  64'(bus.checked_cnt),       64'd5);
    check("pc_valid_pulses", 64'(valid_pulses - base_v), 64'd6);
    check("pc_pass_pulses",  64'(pass_pulses - base_p),  64'd5);

    // rd_wdata ignored for x0, compared otherwise; also pins the 2-cycle latency
    do_reset();
    set_dut(0);
    set_ref(0);
    bus.dut_rd_wdata = 32'h1;
    bus.ref_rd_wdata = 32'h2;
    step();
    clear_inputs();
    check("lat_push_cycle", 64'(bus.cmp_valid), 64'd0);
    step();
    check("x0_cmp_valid",   64'(bus.cmp_valid),   64'd1);
    check("x0_cmp_pass",    64'(bus.cmp_pass),    64'd1);
    check("x0_checked_cnt", 64'(bus.checked_cnt), 64'd1);
    set_dut(1);
    set_ref(1);
    bus.dut_rd_addr  = 5'd3;
    bus.ref_rd_addr  = 5'd3;
    bus.dut_rd_wdata = 32'h1;
    bus.ref_rd_wdata = 32'h2;
    step();
    clear_inputs();
    step();
    check("rd_cmp_valid",  64'(bus.cmp_valid),   64'd1);
    check("rd_cmp_pass",   64'(bus.cmp_pass),    64'd0);
    check("rd_fail",       64'(bus.fail),        64'd1);
    check("rd_fail_code",  64'(bus.fail_code),   64'(FC_RD));
    check("rd_fail_order", bus.fail_order,       64'd1);
    check("rd_checked",    64'(bus.checked_cnt), 64'd1);

    // Overflow on the 9th unmatched DUT push
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_dut(10 + i);
      step();
    end
    check("ovf_not_yet", 64'(bus.fail), 64'd0);
    set_dut(18);
    step();
    clear_inputs();
    check("ovf_fail",       64'(bus.fail),      64'd1);
    check("ovf_fail_code",  64'(bus.fail_code), 64'(FC_OVERFLOW));
    check("ovf_fail_order", bus.fail_order,     64'd10);
    check("ovf_cmp_valid",  64'(bus.cmp_valid), 64'd0);

    // Timeout: one DUT retirement, reference silent
    do_reset();
    set_dut(42);
    step();
    clear_inputs();
    repeat (1023) step();
    check("tmo_not_yet", 64'(bus.fail), 64'd0);
    step();
    check("tmo_fail",       64'(bus.fail),      64'd1);
    check("tmo_fail_code",  64'(bus.fail_code), 64'(FC_TIMEOUT));
    check("tmo_fail_order", bus.fail_order,     64'd0);

    // ORDER beats PC; a stale DUT entry is left behind before the reset
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_dut(i);
      set_ref(i);
      step();
    end
    set_dut(2);
    set_ref(2);
    bus.ref_order = 64'd99;
    bus.ref_pc    = 32'h8000_0100;
    step();
    clear_inputs();
    set_dut(3);
    step();
    clear_inputs();
    step();
    check("ord_fail",        64'(bus.fail),        64'd1);
    check("ord_fail_code",   64'(bus.fail_code),   64'(FC_ORDER));
    check("ord_fail_order",  bus.fail_order,       64'd2);
    check("ord_checked_cnt", 64'(bus.checked_cnt), 64'd2);

    // Asynchronous reset in the middle of a cycle
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_cmp_valid",   64'(bus.cmp_valid),   64'd0);
    check("arst_cmp_pass",    64'(bus.cmp_pass),    64'd0);
    check("arst_fail",        64'(bus.fail),        64'd0);
    check("arst_fail_code",   64'(bus.fail_code),   64'(FC_NONE));
    check("arst_fail_order",  bus.fail_order,       64'd0);
    check("arst_checked_cnt", 64'(bus.checked_cnt), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    base_v = valid_pulses;
    base_p = pass_pulses;
    for (int i = 0; i < 5; i++) begin
      set_dut(i);
      set_ref(i);
      step();
    end
    clear_inputs();
    repeat (3) step();
    check("fresh_checked_cnt", 64'(bus.checked_cnt),      64'd5);
    check("fresh_fail",        64'(bus.fail),             64'd0);
    check("fresh_pass_pulses", 64'(pass_pulses - base_p), 64'd5);

`ifdef RVFI_RETIRE_COMPARE_MEM_EN
    // Masked store data: byte 3 outside wmask is ignored, byte 0 is not
    do_reset();
    set_dut(0);
    set_ref(0);
    bus.dut_mem_wmask = 4'h3;
    bus.ref_mem_wmask = 4'h3;
    bus.dut_mem_wdata = 32'h1122_3344;
    bus.ref_mem_wdata = 32'h9922_3344;
    step();
    set_dut(1);
    set_ref(1);
    bus.dut_mem_wmask = 4'h3;
    bus.ref_mem_wmask = 4'h3;
    bus.dut_mem_wdata = 32'h1122_3344;
    bus.ref_mem_wdata = 32'h1122_3345;
    step();
    clear_inputs();
    step();
    check("mem_b3_checked", 64'(bus.checked_cnt), 64'd1);
    step();
    check("mem_fail",       64'(bus.fail),        64'd1);
    check("mem_fail_code",  64'(bus.fail_code),   64'(FC_MEM));
    check("mem_fail_order", bus.fail_order,       64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvfi_retire_compare.md
Name: rvfi_retire_compare

Overview:
- Sits directly downstream of the ISS-backed reference model.
- Consumes two RVFI retirement streams:
  - the DUT stream, the same signals that feed the reference model;
  - the reference stream, the reference model's `rvfi_o`.
- Buffers each stream, pairs retirements strictly in order, compares the architectural fields, and reports the first divergence or stall as a sticky failure with a cause code.
- Checked-instruction count is exposed for end-of-test reporting.

Parameters:
- XLEN, 32, width of PC and register data.
- DEPTH, 8, entries per retirement FIFO (power of two, ≥ 2).
- TIMEOUT_CYCLES, 1024, maximum cycles one FIFO may stay non-empty while the other is empty.
- CNT_W, 32, width of the checked counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- dut_valid  in  1  DUT retirement strobe
- dut_order  in  64  DUT retirement order
- dut_pc  in  XLEN  DUT retired PC
- dut_insn  in  32  DUT retired instruction
- dut_rd_addr  in  5  DUT destination register
- dut_rd_wdata  in  XLEN  DUT write data
- dut_trap  in  1  DUT trap flag
- ref_valid, ref_order, ref_pc, ref_insn, ref_rd_addr, ref_rd_wdata, ref_trap  in  same widths  reference-model equivalents
- cmp_valid  out  1  one-cycle pulse: a pair was compared
- cmp_pass  out  1  qualifies cmp_valid
- fail  out  1  sticky failure
- fail_code  out  4  cause, enum from package
- fail_order  out  64  DUT order of the failing pair (0 for timeout)
- checked_cnt  out  CNT_W  pairs compared and passed

Behaviour:
- Clock and reset:
  - One clock `clk`.
  - `reset_n` is asynchronous active-low; assertion at any time clears everything immediately.
  - Reset values: FIFOs empty, state IDLE, all outputs 0, `fail_code` = NONE.
  - Deassertion mid-test restarts cleanly; no stale entries survive.
- FIFOs:
  - Each valid retirement is pushed into its own FIFO the same cycle.
  - There is no backpressure.
  - Push onto a full FIFO is legal only if that FIFO pops in the same cycle; otherwise it is an overflow.
- State machine:
  - IDLE → RUN on the first push from either side.
  - RUN → FAIL on a mismatch, overflow, or timeout.
  - FAIL is absorbing until reset.
  - In FAIL, pushes are ignored and no comparison occurs.
- Compare timing:
  - When both FIFO heads are present in RUN, both heads pop.
  - Comparison is registered: `cmp_valid`/`cmp_pass` appear 1 cycle after the pop cycle.
  - A DUT and reference retirement arriving in the same cycle into empty FIFOs yields `cmp_valid` 2 cycles later (push, pop, result).
- Cause priority, checked in this order: ORDER, PC, INSN, TRAP, RD.
  - RD compares `rd_addr` always.
  - RD compares `rd_wdata` only when `rd_addr` != 0.
  - On failure, `fail`, `fail_code` and `fail_order` latch in the same cycle as `cmp_valid`, with `cmp_pass` = 0.
  - `checked_cnt` increments on each pass and saturates at all-ones.
- Timeout:
  - Counter runs while exactly one FIFO is non-empty.
  - It resets whenever both FIFOs are empty or both are non-empty.
  - Reaching TIMEOUT_CYCLES → FAIL, code TIMEOUT, `fail_order` = 0.
- Overflow → FAIL, code OVERFLOW, `fail_order` = the DUT head order if present, else 0.
- Simultaneous events: a compare mismatch and an overflow in the same cycle report MISMATCH causes first; OVERFLOW is lower priority, then TIMEOUT.

Optional Feature:
- Macro: RVFI_RETIRE_COMPARE_MEM_EN.
- When defined:
  - Adds ports `dut_mem_addr`/`ref_mem_addr` (XLEN), `dut_mem_wdata`/`ref_mem_wdata` (XLEN) and `dut_mem_wmask`/`ref_mem_wmask` (XLEN/8).
  - These fields are stored in the FIFO entries.
  - MEM cause is checked after RD; it compares addr and wmask, and wdata only on bytes enabled by wmask.
- When undefined: these ports, the storage and the MEM cause are absent; the MEM enum value still exists and is never produced.

Decomposition:
- Package `rvfi_retire_compare_pkg`:
  - retirement entry struct (order, pc, insn, rd_addr, rd_wdata, trap, optional mem fields);
  - fail-code enum: NONE=0, ORDER, PC, INSN, TRAP, RD, MEM, OVERFLOW, TIMEOUT;
  - FSM state enum.
- One sub-module `rvfi_retire_fifo`, parameterised on entry type and DEPTH, instantiated twice; it provides full/empty flags and simultaneous push/pop on full.

Test Plan:
- 100 identical retirements (orders 0..99), reference delayed 3 cycles → 100 `cmp_pass` pulses, `checked_cnt` = 100, `fail` = 0.
- Pair 5 with `ref_pc` = 0x80000014 vs `dut_pc` = 0x80000018 → `fail` = 1, `fail_code` = PC, `fail_order` = 5, `checked_cnt` = 5, no later `cmp_valid`.
- `rd_addr` = 0, `rd_wdata` differing (0x1 vs 0x2) → pass; `rd_addr` = 3 with the same data → fail, code RD.
- DUT retires 9 instructions with no reference activity, DEPTH = 8 → OVERFLOW on the 9th push; separately, 1 DUT retirement with reference silent → TIMEOUT after 1024 cycles.
- Pair differing in both order and pc → code ORDER; assert `reset_n` low mid-FAIL → all outputs 0 immediately; after release, a fresh identical stream passes.
- With RVFI_RETIRE_COMPARE_MEM_EN: wmask = 0x3 and wdata differing only in byte 3 → pass; differing in byte 0 → fail, code MEM.
